calc_alu: RTL and testbench



---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_alu_if.sv | 30 +++
 rtl/calc_divider.sv | 64 ++++++
 rtl/calc_alu.sv | 161 ++++++++++++++++
 tb/tb_calc_alu.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator arithmetic stage.
//   - operation button encodings (active-low, one button per operation)
//   - display control codes handed to the 7-segment driver
//   - FSM state type for calc_alu
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b1110;
    localparam logic [3:0] OP_SUB  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_NONE = 4'b1111;

    localparam logic [2:0] CODE_NORMAL = 3'd0;
    localparam logic [2:0] CODE_NEG    = 3'd1;
    localparam logic [2:0] CODE_DIVZ   = 3'd2;
    localparam logic [2:0] CODE_QUOT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } calc_state_t;

endpackage

// File: rtl/calc_alu_if.sv
// calc_alu_if: switch/button inputs and result outputs of the arithmetic stage.
//   sw[3:0]        operand value from switches
//   keys[1:0]      active-low operand load keys (0: A, 1: B)
//   arifs[3:0]     active-low operation buttons
//   ind_from_ALU   result magnitude (RES_W bits)
//   c_from_ALU     display control code
//   busy           division in progress
//   valid          one-cycle pulse when a result is written
// master: drives the buttons/switches; slave: the arithmetic stage.
interface calc_alu_if #(
    parameter int RES_W = 11
);
    logic [3:0]       sw;
    logic [1:0]       keys;
    logic [3:0]       arifs;
    logic [RES_W-1:0] ind_from_ALU;
    logic [2:0]       c_from_ALU;
    logic             busy;
    logic             valid;

    modport master (
        output sw, keys, arifs,
        input  ind_from_ALU, c_from_ALU, busy, valid
    );

    modport slave (
        input  sw, keys, arifs,
        output ind_from_ALU, c_from_ALU, busy, valid
    );
endinterface

// File: rtl/calc_divider.sv
// calc_divider: restoring divider, one quotient bit per cycle, MSB first.
//   Clk, rst_n   clock, synchronous active-low reset
//   start        load dividend/divisor and begin (divisor must be nonzero)
//   dividend     RES_W-bit unsigned dividend
//   divisor      4-bit unsigned divisor
//   busy         iteration in progress
//   done         high during the cycle whose edge performs the final iteration
//   quotient     truncated quotient, valid once busy has dropped
module calc_divider #(
    parameter int RES_W = 11
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RES_W-1:0] dividend,
    input  logic [3:0]       divisor,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] quotient
);
    localparam int CNT_W = $clog2(RES_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       rem;
    logic [3:0]       dvsr;
    logic [4:0]       rem_sh;
    logic [4:0]       trial;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        rem_sh = {rem, quotient[RES_W-1]};
        trial  = rem_sh - {1'b0, dvsr};
        done   = busy && (cnt == CNT_W'(1));
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= CNT_W'(RES_W);
            rem      <= '0;
            dvsr     <= divisor;
            quotient <= dividend;
        end else if (busy) begin
            if (rem_sh >= {1'b0, dvsr}) begin
                rem      <= trial[3:0];
                quotient <= {quotient[RES_W-2:0], 1'b1};
            end else begin
                rem      <= rem_sh[3:0];
                quotient <= {quotient[RES_W-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/calc_alu.sv
// calc_alu: sequential arithmetic stage feeding the 7-segment display driver.
//   Clk, rst_n   clock, synchronous active-low reset
//   bus (slave)  sw/keys/arifs inputs; ind_from_ALU, c_from_ALU, busy, valid
// Operands load while their key is held; an operation button press computes
// add/sub/mul in one cycle or a scaled quotient via calc_divider. The result
// is held until the next completed operation.
module calc_alu
    import calc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_SCALE   = 100,
    parameter int RES_W       = 11
) (
    input  logic       Clk,
    input  logic       rst_n,
    calc_alu_if.slave  bus
);
    logic [9:0]       sync_q [SYNC_STAGES];
    logic [3:0]       sw_s;
    logic [1:0]       keys_s;
    logic [3:0]       arifs_s;
    logic [3:0]       arifs_prev;
    logic [3:0]       op_q;
    logic             start_q;
    logic [3:0]       op_a;
    logic [3:0]       op_b;

    calc_state_t      state;
    logic [RES_W-1:0] ind_q;
    logic [2:0]       code_q;
    logic             busy_q;
    logic             valid_q;

    logic             div_go;
    logic             div_busy;
    logic             div_done;
    logic [RES_W-1:0] div_quot;
    logic [RES_W-1:0] dividend;

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= {bus.sw, bus.keys, bus.arifs};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sw_s    = sync_q[SYNC_STAGES-1][9:6];
    assign keys_s  = sync_q[SYNC_STAGES-1][5:4];
    assign arifs_s = sync_q[SYNC_STAGES-1][3:0];

    // A press is a transition from all-released to exactly one button low;
    // requiring the previous sample to be all-released also blocks repeats
    // while a button is held.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            arifs_prev <= OP_NONE;
            op_q       <= OP_NONE;
            start_q    <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            arifs_prev <= arifs_s;
            op_q       <= arifs_s;
            start_q    <= (arifs_prev == OP_NONE) && ($countones(~arifs_s) == 1);
            if (!keys_s[0]) op_a <= sw_s;
            if (!keys_s[1]) op_b <= sw_s;
        end
    end

    assign dividend = RES_W'(op_a) * RES_W'(DIV_SCALE);
    assign div_go   = (state == ST_IDLE) && start_q && (op_q == OP_DIV)
                      && (op_b != 4'd0) && !div_busy;

    calc_divider #(.RES_W(RES_W)) u_div (
        .Clk      (Clk),
        .rst_n    (rst_n),
        .start    (div_go),
        .dividend (dividend),
        .divisor  (op_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // busy drops on the edge of the final iteration, so DONE only publishes
    // the already-settled quotient.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ind_q   <= '0;
            code_q  <= CODE_NORMAL;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        case (op_q)
                            OP_ADD: begin
                                ind_q   <= RES_W'(op_a) + RES_W'(op_b);
                                code_q  <= CODE_NORMAL;
                                valid_q <= 1'b1;
                            end
                            OP_SUB: begin
                                if (op_a >= op_b) begin
                                    ind_q  <= RES_W'(op_a) - RES_W'(op_b);
                                    code_q <= CODE_NORMAL;
                                end else begin
                                    ind_q  <= RES_W'(op_b) - RES_W'(op_a);
                                    code_q <= CODE_NEG;
                                end
                                valid_q <= 1'b1;
                            end
                            OP_MUL: begin
                                ind_q   <= RES_W'(op_a) * RES_W'(op_b);
                                code_q  <= CODE_NORMAL;
                                valid_q <= 1'b1;
                            end
                            OP_DIV: begin
                                if (op_b == 4'd0) begin
                                    ind_q   <= '0;
                                    code_q  <= CODE_DIVZ;
                                    valid_q <= 1'b1;
                                end else begin
                                    busy_q <= 1'b1;
                                    state  <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ind_q   <= div_quot;
                    code_q  <= CODE_QUOT;
                    valid_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ind_from_ALU = ind_q;
    assign bus.c_from_ALU   = code_q;
    assign bus.busy         = busy_q;
    assign bus.valid        = valid_q;
endmodule

// File: tb/tb_calc_alu.sv
// tb_calc_alu: directed self-checking bench for calc_alu.
module tb_calc_alu;
    import calc_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int RES_W       = 11;

    logic Clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    calc_alu_if #(.RES_W(RES_W)) bus ();

    calc_alu #(
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_SCALE   (100),
        .RES_W       (RES_W)
    ) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
        bus.sw   = a;
        bus.keys = 2'b10;
        repeat (4) tick();
        bus.keys = 2'b11;
        repeat (3) tick();
        bus.sw   = b;
        bus.keys = 2'b01;
        repeat (4) tick();
        bus.keys = 2'b11;
        repeat (3) tick();
    endtask

    // Hold the button until valid (or budget expires), then release.
    task automatic do_op(input logic [3:0] op, output int lat, output int bcyc,
                         output int res, output int code);
        lat  = -1;
        bcyc = 0;
        res  = -1;
        code = -1;
        bus.arifs = op;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.busy) bcyc++;
            if (bus.valid) begin
                lat  = k;
                res  = int'(bus.ind_from_ALU);
                code = int'(bus.c_from_ALU);
                break;
            end
        end
        tick();
        check_val("valid_one_cycle", int'(bus.valid), 0);
        bus.arifs = OP_NONE;
        repeat (5) tick();
        check_val("result_held", int'(bus.ind_from_ALU), res);
    endtask

    int lat, bcyc, res, code, nvalid, nbusy;

    initial begin
        rst_n     = 1'b0;
        bus.sw    = 4'd0;
        bus.keys  = 2'b11;
        bus.arifs = OP_NONE;
        repeat (3) tick();
        check_val("rst_ind", int'(bus.ind_from_ALU), 0);
        check_val("rst_code", int'(bus.c_from_ALU), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_valid", int'(bus.valid), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // add 9+5
        load_ops(4'd9, 4'd5);
        do_op(OP_ADD, lat, bcyc, res, code);
        check_val("add_lat", lat, SYNC_STAGES + 2);
        check_val("add_res", res, 14);
        check_val("add_code", code, 0);

        // sub negative then zero
        load_ops(4'd3, 4'd8);
        do_op(OP_SUB, lat, bcyc, res, code);
        check_val("sub_neg_res", res, 5);
        check_val("sub_neg_code", code, 1);
        load_ops(4'd8, 4'd8);
        do_op(OP_SUB, lat, bcyc, res, code);
        check_val("sub_zero_res", res, 0);
        check_val("sub_zero_code", code, 0);

        // mul 15*15
        load_ops(4'd15, 4'd15);
        do_op(OP_MUL, lat, bcyc, res, code);
        check_val("mul_res", res, 225);
        check_val("mul_code", code, 0);

        // divisions
        load_ops(4'd7, 4'd3);
        do_op(OP_DIV, lat, bcyc, res, code);
        check_val("div73_lat", lat, SYNC_STAGES + RES_W + 3);
        check_val("div73_busy", bcyc, 11);
        check_val("div73_res", res, 233);
        check_val("div73_code", code, 4);

        load_ops(4'd15, 4'd1);
        do_op(OP_DIV, lat, bcyc, res, code);
        check_val("div151_res", res, 1500);
        check_val("div151_code", code, 4);

        load_ops(4'd1, 4'd15);
        do_op(OP_DIV, lat, bcyc, res, code);
        check_val("div115_res", res, 6);

        load_ops(4'd5, 4'd0);
        do_op(OP_DIV, lat, bcyc, res, code);
        check_val("divz_lat", lat, SYNC_STAGES + 2);
        check_val("divz_busy", bcyc, 0);
        check_val("divz_res", res, 0);
        check_val("divz_code", code, 2);

        // two buttons low: ignored
        nvalid = 0;
        bus.arifs = 4'b1100;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.valid) nvalid++;
        end
        bus.arifs = OP_NONE;
        repeat (5) tick();
        check_val("multi_btn_valid", nvalid, 0);

        // division with an add press and an A change while busy
        load_ops(4'd7, 4'd3);
        lat = -1;
        res = -1;
        code = -1;
        bus.arifs = OP_DIV;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3)  bus.arifs = OP_NONE;
            if (k == 6)  begin bus.arifs = OP_ADD; bus.sw = 4'd15; bus.keys = 2'b10; end
            if (k == 9)  begin bus.arifs = OP_NONE; bus.keys = 2'b11; end
            if (bus.valid) begin
                lat  = k;
                res  = int'(bus.ind_from_ALU);
                code = int'(bus.c_from_ALU);
                break;
            end
        end
        bus.arifs = OP_NONE;
        bus.keys  = 2'b11;
        check_val("snap_lat", lat, SYNC_STAGES + RES_W + 3);
        check_val("snap_res", res, 233);
        check_val("snap_code", code, 4);
        nvalid = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.valid) nvalid++;
        end
        check_val("busy_press_not_queued", nvalid, 0);
        check_val("busy_press_res", int'(bus.ind_from_ALU), 233);
        // A was reloaded to 15 during the division; B still 3
        do_op(OP_ADD, lat, bcyc, res, code);
        check_val("a_reloaded_add", res, 18);

        // reset mid-division
        load_ops(4'd9, 4'd2);
        bus.arifs = OP_DIV;
        repeat (8) tick();
        check_val("pre_abort_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        bus.arifs = OP_NONE;
        tick();
        check_val("abort_busy", int'(bus.busy), 0);
        check_val("abort_ind", int'(bus.ind_from_ALU), 0);
        check_val("abort_valid", int'(bus.valid), 0);
        rst_n = 1'b1;
        nvalid = 0;
        nbusy  = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.valid) nvalid++;
            if (bus.busy) nbusy++;
        end
        check_val("abort_no_valid", nvalid, 0);
        check_val("abort_no_busy", nbusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
